// File: rtl/mini_core_pipe.sv
// mini_core_pipe: 4-stage IF/LD/EX/WB mini core with RAW bypass or stall,
// halt squash, imem/dmem program port, debug peek and retire counter.
// Ports: clk, rst (sync, active-high); prog_en/prog_inst write imem;
//   dmem_we/dmem_waddr/dmem_wdata preload dmem while prog_en=1;
//   dbg_addr -> dbg_data (combinational dmem peek);
//   halted (sticky), retired_cnt (saturating count of written-back ops).

module mini_core_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int PC_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_en,
  input  logic [2+3*ADDR_W-1:0] prog_inst,
  input  logic                  dmem_we,
  input  logic [ADDR_W-1:0]     dmem_waddr,
  input  logic [DATA_W-1:0]     dmem_wdata,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  halted,
  output logic [15:0]           retired_cnt
);

  localparam int IW = 2 + 3 * ADDR_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] inst;
  } if_ld_t;

  typedef struct packed {
    logic       v;
    logic [1:0] op;
    addr_t      dst;
    data_t      a;
    data_t      b;
  } ld_ex_t;

  typedef struct packed {
    logic       v;
    logic [1:0] op;
    addr_t      dst;
    data_t      res;
  } ex_wb_t;

  logic [IW-1:0]   imem [1<<PC_W];
  data_t           dmem [1<<ADDR_W];
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] prog_ptr;

  if_ld_t if_q;
  ld_ex_t ld_q;
  ex_wb_t ex_q;

  logic [1:0] f_op;
  addr_t      f_s1;
  addr_t      f_s2;
  addr_t      f_dst;

  assign {f_op, f_s1, f_s2, f_dst} = if_q.inst;

  data_t alu;

  always_comb begin
    alu = '0;
    unique case (ld_q.op)
      OP_ADD:  alu = ld_q.a + ld_q.b;
      OP_SUB:  alu = ld_q.a - ld_q.b;
      OP_MUL:  alu = ld_q.a * ld_q.b;
      default: alu = '0;
    endcase
  end

  // Only valid, non-halt ops in LD/EX are producers.
  logic ld_prod;
  logic ex_prod;
  logic s1_ld;
  logic s1_ex;
  logic s2_ld;
  logic s2_ex;
  logic stall;

  assign ld_prod = ld_q.v && (ld_q.op != OP_HLT);
  assign ex_prod = ex_q.v && (ex_q.op != OP_HLT);
  assign s1_ld   = ld_prod && (ld_q.dst == f_s1);
  assign s1_ex   = ex_prod && (ex_q.dst == f_s1);
  assign s2_ld   = ld_prod && (ld_q.dst == f_s2);
  assign s2_ex   = ex_prod && (ex_q.dst == f_s2);

  assign stall = (FWD_EN == 0) && if_q.v &&
                 (s1_ld || s1_ex || s2_ld || s2_ex);

  data_t opa;
  data_t opb;

  // LD match is the younger producer, so it beats EX.
  always_comb begin
    opa = dmem[f_s1];
    opb = dmem[f_s2];
    if (FWD_EN != 0) begin
      if (s1_ld)      opa = alu;
      else if (s1_ex) opa = ex_q.res;
      if (s2_ld)      opb = alu;
      else if (s2_ex) opb = ex_q.res;
    end
  end

  logic halt_now;
  logic wb_en;

  assign halt_now = ex_q.v && (ex_q.op == OP_HLT);
  assign wb_en    = ex_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      prog_ptr    <= '0;
      if_q.v      <= 1'b0;
      ld_q.v      <= 1'b0;
      ex_q.v      <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else if (prog_en) begin
      prog_ptr <= prog_ptr + PC_W'(1);
      pc       <= '0;
      if_q.v   <= 1'b0;
      ld_q.v   <= 1'b0;
      ex_q.v   <= 1'b0;
      halted   <= 1'b0;
    end else if (halted) begin
      pc <= pc;
    end else if (halt_now) begin
      // Younger ops in IF/LD are squashed.
      halted <= 1'b1;
      if_q.v <= 1'b0;
      ld_q.v <= 1'b0;
      ex_q.v <= 1'b0;
    end else begin
      if (!stall) begin
        if_q.v    <= 1'b1;
        if_q.inst <= imem[pc];
        pc        <= pc + PC_W'(1);
      end
      ld_q.v   <= if_q.v && !stall;
      ld_q.op  <= f_op;
      ld_q.dst <= f_dst;
      ld_q.a   <= opa;
      ld_q.b   <= opb;
      ex_q.v   <= ld_q.v;
      ex_q.op  <= ld_q.op;
      ex_q.dst <= ld_q.dst;
      ex_q.res <= alu;
      if (wb_en && (retired_cnt != 16'hFFFF)) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (prog_en) begin
        imem[prog_ptr] <= prog_inst;
        if (dmem_we) begin
          dmem[dmem_waddr] <= dmem_wdata;
        end
      end else if (!halted && wb_en) begin
        dmem[ex_q.dst] <= ex_q.res;
      end
    end
  end

  assign dbg_data = dmem[dbg_addr];

endmodule

// File: tb/tb_mini_core_pipe.sv
// tb_mini_core_pipe: random and directed programs on three core builds,
// checked every cycle against an in-order schedule/value model.

module tb_mini_core_pipe;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int IW = 2 + 3 * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    pe;
  logic [IW-1:0] prog_inst;
  logic          dmem_we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] dbg_addr;

  logic [DW-1:0] dbg_f, dbg_s, dbg_w;
  logic          h_f, h_s, h_w;
  logic [15:0]   r_f, r_s, r_w;

  always #5 clk = ~clk;

  mini_core_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .PC_W(5), .FWD_EN(1)
  ) u_f (
    .clk(clk), .rst(rst), .prog_en(pe[0]),
    .prog_inst(prog_inst), .dmem_we(dmem_we),
    .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_f),
    .halted(h_f), .retired_cnt(r_f)
  );

  mini_core_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .PC_W(5), .FWD_EN(0)
  ) u_s (
    .clk(clk), .rst(rst), .prog_en(pe[1]),
    .prog_inst(prog_inst), .dmem_we(dmem_we),
    .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_s),
    .halted(h_s), .retired_cnt(r_s)
  );

  mini_core_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .PC_W(2), .FWD_EN(1)
  ) u_w (
    .clk(clk), .rst(rst), .prog_en(pe[2]),
    .prog_inst(prog_inst), .dmem_we(dmem_we),
    .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dbg_addr(dbg_addr), .dbg_data(dbg_w),
    .halted(h_w), .retired_cnt(r_w)
  );

  logic [IW-1:0] prog [32];
  logic [DW-1:0] mem_init [64];
  logic [DW-1:0] mem_m [64];
  int            n_chk;
  int            n_pass;
  int            ret_base;
  logic [AW-1:0] pend_dst;

  function automatic logic [IW-1:0] mk(input int op, input int a,
                                       input int b, input int d);
    return {2'(op), AW'(a), AW'(b), AW'(d)};
  endfunction

  function automatic int get_d(input int s);
    if (s == 0) return int'(dbg_f);
    if (s == 1) return int'(dbg_s);
    return int'(dbg_w);
  endfunction

  function automatic int get_h(input int s);
    if (s == 0) return int'(h_f);
    if (s == 1) return int'(h_s);
    return int'(h_w);
  endfunction

  function automatic int get_r(input int s);
    if (s == 0) return int'(r_f);
    if (s == 1) return int'(r_s);
    return int'(r_w);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic peek(input int sel, input int a, input int exp,
                      input string nm);
    dbg_addr = AW'(a);
    #1;
    chk(nm, get_d(sel), exp);
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 32; i++) prog[i] = mk(3, 0, 0, 0);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 64; i++) mem_init[i] = DW'($urandom);
  endtask

  task automatic load(input int sel, input int depth);
    @(negedge clk);
    rst = 1'b1; pe = '0; dmem_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_halted", get_h(sel), 0);
    chk("rst_retired", get_r(sel), 0);
    for (int i = 0; i < 64; i++) begin
      pe = '0;
      pe[sel] = 1'b1;
      dmem_we = 1'b1;
      waddr = AW'(i);
      wdata = mem_init[i];
      prog_inst = prog[i % depth];
      @(negedge clk);
    end
    pe = '0;
    dmem_we = 1'b0;
    #1;
    chk("prog_halted", get_h(sel), 0);
    mem_m = mem_init;
    ret_base = 0;
  endtask

  // Model: in-order execution gives the values; each op leaves IF at
  // edge L (n+2 with bypass, else held until every matching older
  // write has landed), writes at L+2; a halt sets halted at L+2.
  task automatic run(input int sel, input int depth, input bit fwd,
                     input int ncyc, input int exp_h);
    logic [DW-1:0] sm [64];
    int            wq [$];
    logic [AW-1:0] dq [$];
    logic [DW-1:0] vq [$];
    int            hedge;
    int            prev_l;
    int            n;
    int            l;
    int            wi;
    logic [IW-1:0] ins;
    logic [1:0]    op;
    logic [AW-1:0] s1, s2, d;
    logic [DW-1:0] v;
    sm = mem_m;
    hedge = 1 << 30;
    prev_l = 1;
    n = 0;
    while (n < 1000) begin
      ins = prog[n % depth];
      {op, s1, s2, d} = ins;
      l = fwd ? n + 2 : prev_l + 1;
      if (!fwd) begin
        for (int p = 0; p < wq.size(); p++) begin
          if ((dq[p] == s1 || dq[p] == s2) && wq[p] + 1 > l)
            l = wq[p] + 1;
        end
      end
      prev_l = l;
      if (l > ncyc) break;
      if (op == 2'b11) begin
        hedge = l + 2;
        break;
      end
      case (op)
        2'b00:   v = sm[s1] + sm[s2];
        2'b01:   v = sm[s1] - sm[s2];
        default: v = sm[s1] * sm[s2];
      endcase
      sm[d] = v;
      wq.push_back(l + 2);
      dq.push_back(d);
      vq.push_back(v);
      n++;
    end
    if (exp_h > 0) chk("model_halt_edge", hedge, exp_h);
    wi = 0;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      while (wi < wq.size() && wq[wi] == t) begin
        mem_m[dq[wi]] = vq[wi];
        wi++;
      end
      dbg_addr = AW'($urandom);
      #1;
      chk($sformatf("dbg_data@%0d", t), get_d(sel),
          int'(mem_m[dbg_addr]));
      chk($sformatf("halted@%0d", t), get_h(sel), int'(t >= hedge));
      chk($sformatf("retired@%0d", t), get_r(sel), ret_base + wi);
    end
    ret_base += wi;
    pend_dst = (wi < wq.size()) ? dq[wi] : AW'($urandom);
  endtask

  task automatic rand_prog(input int len);
    fill_halt();
    for (int i = 0; i < len; i++) begin
      prog[i] = mk($urandom_range(0, 2), $urandom_range(1, 7),
                   $urandom_range(1, 7), $urandom_range(1, 7));
    end
    rand_mem();
  endtask

  initial begin
    int len;
    int sel;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    pe = '0;
    dmem_we = 1'b0;
    waddr = '0;
    wdata = '0;
    prog_inst = '0;
    dbg_addr = '0;

    // Dependency chain, bypass then stall build.
    for (int b = 0; b < 2; b++) begin
      fill_halt();
      prog[0] = mk(0, 1, 2, 3);
      prog[1] = mk(2, 3, 3, 4);
      prog[2] = mk(1, 4, 1, 5);
      rand_mem();
      mem_init[1] = 8'd5;
      mem_init[2] = 8'd3;
      load(b, 32);
      run(b, 32, b == 0, b == 0 ? 10 : 14, b == 0 ? 7 : 11);
      peek(b, 3, 8, "chain_d3");
      peek(b, 4, 64, "chain_d4");
      peek(b, 5, 59, "chain_d5");
      chk("chain_retired", get_r(b), 3);
    end

    // prog_en clears a halted core but keeps retired_cnt.
    pe[1] = 1'b1;
    prog_inst = prog[0];
    @(negedge clk);
    pe = '0;
    #1;
    chk("prog_clears_halt", get_h(1), 0);
    chk("prog_keeps_retired", get_r(1), 3);

    // Wrap-around arithmetic.
    fill_halt();
    prog[0] = mk(2, 1, 1, 6);
    prog[1] = mk(1, 2, 3, 7);
    rand_mem();
    mem_init[1] = 8'd20;
    mem_init[2] = 8'd3;
    mem_init[3] = 8'd5;
    load(0, 32);
    run(0, 32, 1'b1, 8, 6);
    peek(0, 6, 144, "wrap_mul");
    peek(0, 7, 254, "wrap_sub");

    // Squash after halt.
    fill_halt();
    prog[1] = mk(0, 1, 2, 9);
    rand_mem();
    mem_init[9] = 8'd0;
    load(1, 32);
    run(1, 32, 1'b0, 8, 4);
    peek(1, 9, 0, "squash_d9");
    chk("squash_retired", get_r(1), 0);

    // PC wrap on the 4-entry imem build.
    for (int i = 0; i < 32; i++) prog[i] = mk(0, 1, 1, 1);
    rand_mem();
    mem_init[1] = 8'd1;
    load(2, 4);
    run(2, 4, 1'b1, 8, -1);
    peek(2, 1, 32, "pcwrap_d1");
    chk("pcwrap_retired", get_r(2), 5);

    // Random programs on both hazard policies.
    for (int r = 0; r < 12; r++) begin
      sel = r % 2;
      len = $urandom_range(3, 14);
      rand_prog(len);
      load(sel, 32);
      run(sel, 32, sel == 0, 3 * len + 8, -1);
    end

    // Reset mid-run: no writes, state cleared, memory kept.
    for (int b = 0; b < 2; b++) begin
      rand_prog(12);
      load(b, 32);
      run(b, 32, b == 0, 7, -1);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        dbg_addr = (c == 0) ? pend_dst : AW'($urandom);
        #1;
        chk("rst_mid_dbg", get_d(b), int'(mem_m[dbg_addr]));
        chk("rst_mid_halted", get_h(b), 0);
        chk("rst_mid_retired", get_r(b), 0);
      end
    end

    // prog_en mid-run: flush, restart from pc 0 on current memory.
    rand_prog(10);
    load(1, 32);
    run(1, 32, 1'b0, 9, -1);
    pe[1] = 1'b1;
    dmem_we = 1'b0;
    prog_inst = prog[0];
    @(negedge clk);
    pe = '0;
    dbg_addr = pend_dst;
    #1;
    chk("prog_mid_dbg", get_d(1), int'(mem_m[dbg_addr]));
    chk("prog_mid_retired", get_r(1), ret_base);
    run(1, 32, 1'b0, 40, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mini_core_pipe.md
Name: mini_core_pipe

Overview:
Parametrised successor of the 4-stage mini core, with stages IF (fetch), LD (operand read), EX (ALU) and WB (write-back).
- Generalised data width, data-memory depth and instruction-memory depth.
- Adds a selectable RAW hazard policy (forwarding or stall), squashing after halt, a data-memory preload port, a debug read port and a retired-instruction counter.
- Instruction word: {op[1:0], src1, src2, dst}. Each address field is ADDR_W bits.

Parameters:
- DATA_W, 8: data word width; ALU results are truncated to DATA_W.
- ADDR_W, 6: data-memory address width; depth is 2^ADDR_W.
- PC_W, 5: instruction-memory address width; depth is 2^PC_W.
- FWD_EN, 1: 1 = bypass forwarding, 0 = stall on RAW hazard.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- prog_en  in  1  1 = program mode (load imem/dmem, pipeline held); 0 = run.
- prog_inst  in  2+3*ADDR_W  instruction written to imem[prog_ptr] while prog_en=1.
- dmem_we  in  1  preload write strobe; honoured only while prog_en=1.
- dmem_waddr  in  ADDR_W  preload address.
- dmem_wdata  in  DATA_W  preload data.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational dmem[dbg_addr].
- halted  out  1  sticky; set when a halt instruction completes.
- retired_cnt  out  16  count of non-halt instructions written back.

Behaviour:
- Opcodes:
  - 00: dst = src1 + src2.
  - 01: dst = src1 − src2.
  - 10: dst = low DATA_W bits of src1 × src2.
  - 11: halt.
  - All arithmetic is unsigned, mod 2^DATA_W.
- Reset (rst=1 at edge):
  - pc=0, prog_ptr=0.
  - All stage valid bits 0; halted=0; retired_cnt=0.
  - Memory contents are preserved.
- Program mode (prog_en=1):
  - Each edge: imem[prog_ptr]<=prog_inst, then prog_ptr++ (wraps at 2^PC_W).
  - If dmem_we=1: dmem[dmem_waddr]<=dmem_wdata.
  - Every edge also forces pc=0, all valid bits 0, halted=0.
  - prog_ptr is cleared only by rst.
- Run mode (prog_en=0, halted=0), per edge:
  - IF: if_inst<=imem[pc]; if_v<=1; pc++ (wraps from 2^PC_W−1 to 0).
  - LD: operands read combinationally from dmem using if_inst fields and muxed through forwarding; latched with op and dst.
  - EX: alu result latched with dst and op.
  - WB: if ex_v and op≠11, dmem[ex_dst]<=ex_res and retired_cnt++. retired_cnt saturates at 0xFFFF.
- Latency: the instruction at pc k (no stalls, first run edge = edge 1) writes dmem at edge k+4.
- Hazards: compare each IF-stage source against the LD-stage dst and the EX-stage dst, valid non-halt only.
  - FWD_EN=1:
    - LD match: use the current alu output.
    - EX match: use ex_res.
    - Both match: the LD match (younger producer) wins.
    - No stalls ever.
  - FWD_EN=0: on any match, hold pc and if_inst and inject a bubble (ld_v<=0). A dependent instruction at distance 1 stalls exactly 2 cycles.
  - WB-stage write and same-cycle dmem read: the read sees the old value. This is covered by the EX-match forward/stall rule.
  - A source equal to the dst of the same instruction is not a hazard.
- Halt:
  - When ex_v=1 and ex_op=11, the next edge sets halted<=1 and clears if_v, ld_v and ex_v, so younger instructions are squashed.
  - While halted, pc and all state are frozen and no dmem writes occur.
  - halted is cleared by rst or prog_en=1.
- Priority per edge: rst > prog_en > halted > run.
- dbg_data is always live, including during run and halt.

Test Plan:
- FWD_EN=1 dependency chain:
  - Preload dmem[1]=5, dmem[2]=3.
  - Program: add 1,2→3; mul 3,3→4; sub 4,1→5; halt.
  - Required: dmem[3]=8, dmem[4]=64, dmem[5]=59; halted rises at edge 7; retired_cnt=3.
- FWD_EN=0, same program: identical memory results; halted rises at edge 11 (4 stall cycles).
- Wrap-around arithmetic:
  - Preload dmem[1]=20, dmem[2]=3, dmem[3]=5.
  - Program: mul 1,1→6; sub 2,3→7; halt.
  - Required: dmem[6]=144, dmem[7]=254.
- Squash after halt:
  - Program: halt; add 1,2→9 (dmem[9]=0 before).
  - Required: dmem[9] stays 0; retired_cnt=0; pc frozen.
- PC wrap (PC_W=2):
  - Fill all 4 slots with add 1,1→1, dmem[1]=1.
  - Required: after 8 run edges the pc has wrapped and dmem[1] keeps doubling mod 256.
- Reset / re-program mid-run:
  - Assert rst mid-run: no further writes, halted=0, dmem contents retained (check via dbg_data).
  - Assert prog_en mid-run: pipeline flushed, pc=0.
